// File: rtl/lcd_value_formatter.sv
// Converts a 16-bit reading into five ASCII decimal digits (serial double-dabble)
// and writes them as paced single-cycle strobes into an LCD character buffer.
module lcd_value_formatter #(
   parameter logic [4:0]  BASE_ADDR  = 5'd16,
   parameter int unsigned WR_GAP     = 3,
   parameter bit          BLANK_LEAD = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        val_valid,
   input  logic [15:0] val_data,
   output logic        W,
   output logic [4:0]  WADD,
   output logic [7:0]  DIN,
   output logic        busy,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CONV  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   localparam logic [7:0] GAP = 8'(WR_GAP);

   state_t      r_state;
   logic [19:0] r_bcd;
   logic [15:0] r_bin;
   logic [3:0]  r_cnt;
   logic [2:0]  r_idx;
   logic [7:0]  r_gap;
   logic        r_nz;
   logic        r_pend;
   logic [15:0] r_pend_data;
   logic        r_w;
   logic [4:0]  r_wadd;
   logic [7:0]  r_din;
   logic        r_busy;

   logic [19:0] w_bcd_adj;
   logic [3:0]  w_digit;
   logic        w_blank;
   logic [7:0]  w_char;
   logic        w_restart;
   logic [15:0] w_next_data;
   logic        w_last;

   // Add-3 correction applied to every BCD nibble before the shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int k = 0; k < 5; k++) begin
         if (r_bcd[4*k +: 4] >= 4'd5) begin
            w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      case (r_idx)
         3'd0:    w_digit = r_bcd[19:16];
         3'd1:    w_digit = r_bcd[15:12];
         3'd2:    w_digit = r_bcd[11:8];
         3'd3:    w_digit = r_bcd[7:4];
         default: w_digit = r_bcd[3:0];
      endcase
   end

   // r_nz remembers whether a non-zero digit was already written; units never blank.
   assign w_blank     = BLANK_LEAD && !r_nz && (w_digit == 4'd0) && (r_idx != 3'd4);
   assign w_char      = w_blank ? 8'h20 : {4'h3, w_digit};
   assign w_restart   = val_valid || r_pend;
   assign w_next_data = val_valid ? val_data : r_pend_data;
   assign w_last      = (r_idx == 3'd5);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_bcd       <= '0;
         r_bin       <= '0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_gap       <= '0;
         r_nz        <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_data <= '0;
         r_w         <= 1'b0;
         r_wadd      <= '0;
         r_din       <= '0;
         r_busy      <= 1'b0;
      end else begin
         if (r_state != S_IDLE && val_valid) begin
            r_pend      <= 1'b1;
            r_pend_data <= val_data;
         end
         case (r_state)
            S_IDLE: begin
               r_w <= 1'b0;
               if (val_valid) begin
                  r_bin   <= val_data;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               r_w            <= 1'b0;
               {r_bcd, r_bin} <= {w_bcd_adj[18:0], r_bin, 1'b0};
               r_cnt          <= r_cnt + 4'd1;
               if (r_cnt == 4'd15) begin
                  r_idx   <= '0;
                  r_gap   <= '0;
                  r_nz    <= 1'b0;
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (r_gap != 8'd0) begin
                  r_w   <= 1'b0;
                  r_gap <= r_gap - 8'd1;
               end else if (w_last) begin
                  r_w <= 1'b0;
                  // A strobe arriving on this very edge is newer than the pending one.
                  if (w_restart) begin
                     r_bin   <= w_next_data;
                     r_bcd   <= '0;
                     r_cnt   <= '0;
                     r_pend  <= 1'b0;
                     r_state <= S_CONV;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_w    <= 1'b1;
                  r_wadd <= BASE_ADDR + {2'b00, r_idx};
                  r_din  <= w_char;
                  if (w_digit != 4'd0) begin
                     r_nz <= 1'b1;
                  end
                  r_idx  <= r_idx + 3'd1;
                  r_gap  <= (r_idx == 3'd4) ? 8'd0 : GAP;
               end
            end
            default: begin
               r_w     <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign W           = r_w;
   assign WADD        = r_wadd;
   assign DIN         = r_din;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Directed bench for lcd_value_formatter: two instances with different address,
// gap and blanking settings share one stimulus stream.
module tb_lcd_value_formatter;

   logic        clk;
   logic        reset;
   logic        val_valid;
   logic [15:0] val_data;

   logic        W_a, W_b;
   logic [4:0]  WADD_a, WADD_b;
   logic [7:0]  DIN_a, DIN_b;
   logic        busy_a, busy_b;
   logic [1:0]  st_a, st_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   int tdum  = 0;
   int fall_a = -1;
   int fall_b = -1;
   logic busy_q_a = 1'b0;
   logic busy_q_b = 1'b0;

   // entry = {offset from strobe edge, WADD, DIN}
   logic [20:0] got_a[$];
   logic [20:0] got_b[$];
   logic [20:0] exp_a[$];
   logic [20:0] exp_b[$];

   lcd_value_formatter #(.BASE_ADDR(5'd16), .WR_GAP(3), .BLANK_LEAD(1'b1)) dut_a (
      .clk(clk), .reset(reset), .val_valid(val_valid), .val_data(val_data),
      .W(W_a), .WADD(WADD_a), .DIN(DIN_a), .busy(busy_a), .o_dbg_state(st_a)
   );

   lcd_value_formatter #(.BASE_ADDR(5'd30), .WR_GAP(0), .BLANK_LEAD(1'b0)) dut_b (
      .clk(clk), .reset(reset), .val_valid(val_valid), .val_data(val_data),
      .W(W_b), .WADD(WADD_b), .DIN(DIN_b), .busy(busy_b), .o_dbg_state(st_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // write monitor
   always @(negedge clk) begin
      if (W_a === 1'b1) got_a.push_back({8'(cyc - t0), WADD_a, DIN_a});
      if (W_b === 1'b1) got_b.push_back({8'(cyc - t0), WADD_b, DIN_b});
      if (busy_q_a && !busy_a) fall_a = cyc - t0;
      if (busy_q_b && !busy_b) fall_b = cyc - t0;
      busy_q_a = busy_a;
      busy_q_b = busy_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic strobe(input logic [15:0] v, output int t);
      @(negedge clk);
      val_valid = 1'b1;
      val_data  = v;
      t = cyc + 1;
      @(negedge clk);
      val_valid = 1'b0;
   endtask

   task automatic start_run(input logic [15:0] v);
      got_a.delete();
      got_b.delete();
      exp_a.delete();
      exp_b.delete();
      fall_a = -1;
      fall_b = -1;
      strobe(v, t0);
      chk("busy_a_rise", 32'(busy_a), 32'd1);
      chk("busy_b_rise", 32'(busy_b), 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_a !== 1'b0 || busy_b !== 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(n < 300), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic expect_a(input int off0, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] c4);
      logic [7:0] c[5];
      c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3; c[4] = c4;
      for (int i = 0; i < 5; i++) exp_a.push_back({8'(off0 + 4 * i), 5'(16 + i), c[i]});
   endtask

   task automatic expect_b(input int off0, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] c4);
      logic [7:0] c[5];
      logic [4:0] ad[5];
      c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3; c[4] = c4;
      ad[0] = 5'd30; ad[1] = 5'd31; ad[2] = 5'd0; ad[3] = 5'd1; ad[4] = 5'd2;
      for (int i = 0; i < 5; i++) exp_b.push_back({8'(off0 + i), ad[i], c[i]});
   endtask

   // scoreboard
   task automatic compare(input string tag);
      chk({tag, "_cnt_a"}, 32'(got_a.size()), 32'(exp_a.size()));
      chk({tag, "_cnt_b"}, 32'(got_b.size()), 32'(exp_b.size()));
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
         chk($sformatf("%s_a%0d", tag, i), 32'(got_a[i]), 32'(exp_a[i]));
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
   endtask

   initial begin
      int n;
      reset     = 1'b0;
      val_valid = 1'b0;
      val_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_W_a", 32'(W_a), 32'd0);
      chk("rst_WADD_a", 32'(WADD_a), 32'd0);
      chk("rst_DIN_a", 32'(DIN_a), 32'd0);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_st_a", 32'(st_a), 32'd0);
      chk("rst_W_b", 32'(W_b), 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // basic conversion and pacing
      start_run(16'd12345);
      wait_idle();
      expect_a(17, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35);
      expect_b(17, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35);
      compare("v12345");
      chk("fall_a_12345", 32'(fall_a), 32'd34);
      chk("fall_b_12345", 32'(fall_b), 32'd22);

      start_run(16'd0);
      wait_idle();
      expect_a(17, 8'h20, 8'h20, 8'h20, 8'h20, 8'h30);
      expect_b(17, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30);
      compare("v0");

      start_run(16'd7);
      wait_idle();
      expect_a(17, 8'h20, 8'h20, 8'h20, 8'h20, 8'h37);
      expect_b(17, 8'h30, 8'h30, 8'h30, 8'h30, 8'h37);
      compare("v7");

      start_run(16'd65535);
      wait_idle();
      expect_a(17, 8'h36, 8'h35, 8'h35, 8'h33, 8'h35);
      expect_b(17, 8'h36, 8'h35, 8'h35, 8'h33, 8'h35);
      compare("v65535");

      start_run(16'd1000);
      wait_idle();
      expect_a(17, 8'h20, 8'h31, 8'h30, 8'h30, 8'h30);
      expect_b(17, 8'h30, 8'h31, 8'h30, 8'h30, 8'h30);
      compare("v1000");

      // pending value, latest wins, busy stays high across both sequences
      start_run(16'd100);
      strobe(16'd200, tdum);
      strobe(16'd300, tdum);
      wait_idle();
      expect_a(17, 8'h20, 8'h20, 8'h31, 8'h30, 8'h30);
      expect_a(51, 8'h20, 8'h20, 8'h33, 8'h30, 8'h30);
      expect_b(17, 8'h30, 8'h30, 8'h31, 8'h30, 8'h30);
      expect_b(39, 8'h30, 8'h30, 8'h33, 8'h30, 8'h30);
      compare("pend");
      chk("fall_a_pend", 32'(fall_a), 32'd68);
      chk("fall_b_pend", 32'(fall_b), 32'd44);

      // reset mid-write discards partial sequence and pending value
      start_run(16'd500);
      strobe(16'd600, tdum);
      n = 0;
      while (cyc - t0 < 21 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_wait", 32'(n < 100), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("midrst_W_a", 32'(W_a), 32'd0);
      chk("midrst_busy_a", 32'(busy_a), 32'd0);
      chk("midrst_W_b", 32'(W_b), 32'd0);
      chk("midrst_busy_b", 32'(busy_b), 32'd0);
      chk("midrst_WADD_a", 32'(WADD_a), 32'd0);
      chk("midrst_DIN_a", 32'(DIN_a), 32'd0);
      chk("midrst_cnt_a", 32'(got_a.size()), 32'd2);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (60) @(negedge clk);
      chk("post_cnt_a", 32'(got_a.size()), 32'd2);
      chk("post_cnt_b", 32'(got_b.size()), 32'd5);
      chk("post_busy_a", 32'(busy_a), 32'd0);
      chk("post_busy_b", 32'(busy_b), 32'd0);
      chk("post_st_a", 32'(st_a), 32'd0);

      start_run(16'd42);
      wait_idle();
      expect_a(17, 8'h20, 8'h20, 8'h20, 8'h34, 8'h32);
      expect_b(17, 8'h30, 8'h30, 8'h30, 8'h34, 8'h32);
      compare("v42");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
